// File: rtl/array_mul_seq.sv
// Element-wise multiply sequencer: walks C[i] = A[i] * B[i] over a word-addressed memory.
// One element costs three cycles (read A, read B, write C); done pulses for one cycle at the end.
//
// state | meaning
// IDLE  | waiting for start, memory port quiet
// RD_A  | addressing A[i], capturing operand A
// RD_B  | addressing B[i], capturing truncated product
// WR_C  | writing product to C[i], advancing index
// DONE  | one-cycle completion pulse
module array_mul_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] base_c,
    input  logic [LEN_W-1:0]  len,
    output logic              busy,
    output logic              done,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datain,
    input  logic [DATA_W-1:0] mem_dataout
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD_A = 3'd1,
        S_RD_B = 3'd2,
        S_WR_C = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_base_a;
    logic [ADDR_W-1:0]   r_base_b;
    logic [ADDR_W-1:0]   r_base_c;
    logic [LEN_W-1:0]    r_len;
    logic [LEN_W-1:0]    r_idx;
    logic [DATA_W-1:0]   r_a;
    logic [DATA_W-1:0]   r_prod;
    logic [ADDR_W-1:0]   w_idx;
    logic                w_last;
    logic                w_accept;

    assign w_idx    = ADDR_W'(r_idx);
    assign w_last   = (r_idx == (r_len - LEN_W'(1)));
    assign w_accept = (r_state == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = (len == '0) ? S_DONE : S_RD_A;
                end
            end
            S_RD_A:  w_next = S_RD_B;
            S_RD_B:  w_next = S_WR_C;
            S_WR_C:  w_next = w_last ? S_DONE : S_RD_A;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (r_state != S_IDLE);
        done       = (r_state == S_DONE);
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_datain = '0;
        case (r_state)
            S_RD_A: mem_addr = r_base_a + w_idx;
            S_RD_B: mem_addr = r_base_b + w_idx;
            S_WR_C: begin
                mem_addr   = r_base_c + w_idx;
                mem_datain = r_prod;
                mem_write  = 1'b1;
            end
            default: ;
        endcase
    end

    // Operands and bases are captured only on an accepted start, so input changes mid-run are invisible.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_c <= '0;
            r_len    <= '0;
            r_idx    <= '0;
            r_a      <= '0;
            r_prod   <= '0;
        end else begin
            if (w_accept) begin
                r_base_a <= base_a;
                r_base_b <= base_b;
                r_base_c <= base_c;
                r_len    <= len;
                r_idx    <= '0;
            end
            if (r_state == S_RD_A) begin
                r_a <= mem_dataout;
            end
            if (r_state == S_RD_B) begin
                r_prod <= r_a * mem_dataout;
            end
            if ((r_state == S_WR_C) && !w_last) begin
                r_idx <= r_idx + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_array_mul_seq.sv
// Bench for array_mul_seq: behavioural word memory, directed scenarios plus randomized runs
// checked against an element-by-element reference of the whole memory image.
module tb_array_mul_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] base_a;
    logic [15:0] base_b;
    logic [15:0] base_c;
    logic [15:0] len;
    logic        busy;
    logic        done;
    logic        mem_write;
    logic [15:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;

    logic [31:0] mem     [0:65535];
    logic [31:0] ref_mem [0:65535];
    int          wr_count;
    int          checks;
    int          failures;

    array_mul_seq #(.ADDR_W(16), .DATA_W(32), .LEN_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_a     (base_a),
        .base_b     (base_b),
        .base_c     (base_c),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .mem_write  (mem_write),
        .mem_addr   (mem_addr),
        .mem_datain (mem_datain),
        .mem_dataout(mem_dataout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_dataout = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_write) begin
            mem[mem_addr] = mem_datain;
            wr_count = wr_count + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic sync_ref();
        for (int i = 0; i < 65536; i++) ref_mem[i] = mem[i];
    endtask

    // Reference: elements processed in order, each read before its own C word is written.
    task automatic model_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                            input int n);
        logic [15:0] ia, ib, ic;
        logic [63:0] full;
        for (int i = 0; i < n; i++) begin
            ia = a + 16'(i);
            ib = b + 16'(i);
            ic = c + 16'(i);
            full = 64'(ref_mem[ia]) * 64'(ref_mem[ib]);
            ref_mem[ic] = full[31:0];
        end
    endtask

    task automatic compare_mem(input string tag);
        int nmis;
        int first;
        nmis  = 0;
        first = -1;
        for (int i = 0; i < 65536; i++) begin
            if (mem[i] !== ref_mem[i]) begin
                nmis = nmis + 1;
                if (first < 0) first = i;
            end
        end
        if (first >= 0) $display("note %s first differing addr=%h", tag, first);
        check(tag, 32'(nmis), 32'd0);
    endtask

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c,
                          input int n, input bit extra);
        int cyc;
        int wr0;
        @(negedge clk);
        base_a = a;
        base_b = b;
        base_c = c;
        len    = 16'(n);
        start  = 1'b1;
        wr0    = wr_count;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        while (!done && cyc < 3 * n + 20) begin
            if (extra && cyc == 4) begin
                start  = 1'b1;
                base_a = a + 16'd7;
                base_c = c + 16'd3;
                len    = 16'(n + 2);
            end else if (extra && cyc == 5) begin
                start = 1'b0;
            end
            @(negedge clk);
            cyc = cyc + 1;
        end
        check("done_latency", 32'(cyc), 32'(3 * n + 1));
        check("busy_in_done", 32'(busy), 32'd1);
        check("no_write_in_done", 32'(mem_write), 32'd0);
        if (extra) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check("write_count", 32'(wr_count - wr0), 32'(n));
        if (extra) begin
            @(negedge clk);
            check("start_in_done_ignored", 32'(busy), 32'd0);
        end
    endtask

    task automatic load_t1();
        for (int i = 0; i < 4; i++) begin
            mem[i]      = (i == 1) ? 32'd2 : (i == 3) ? 32'd3 : 32'd1;
            mem[4 + i]  = mem[i];
            mem[20 + i] = 32'hDEAD_0020 + 32'(i);
        end
    endtask

    initial begin
        int n;
        logic [15:0] a, b, c;
        checks   = 0;
        failures = 0;
        wr_count = 0;
        reset    = 1'b0;
        start    = 1'b0;
        base_a   = '0;
        base_b   = '0;
        base_c   = '0;
        len      = '0;
        for (int i = 0; i < 65536; i++) mem[i] = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_write", 32'(mem_write), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_datain", mem_datain, 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // T1 basic
        load_t1();
        sync_ref();
        run_op(16'd0, 16'd4, 16'd20, 4, 1'b0);
        check("t1_c0", mem[20], 32'd1);
        check("t1_c1", mem[21], 32'd4);
        check("t1_c2", mem[22], 32'd1);
        check("t1_c3", mem[23], 32'd9);
        model_op(16'd0, 16'd4, 16'd20, 4);
        compare_mem("t1_mem");

        // T2 zero length
        sync_ref();
        run_op(16'd0, 16'd4, 16'd20, 0, 1'b0);
        compare_mem("t2_mem");

        // T3 truncation
        mem[100] = 32'h0001_0000;
        mem[200] = 32'h0001_0000;
        mem[300] = 32'h1234_5678;
        sync_ref();
        run_op(16'd100, 16'd200, 16'd300, 1, 1'b0);
        check("t3_trunc_a", mem[300], 32'h0000_0000);
        mem[101] = 32'hFFFF_FFFF;
        mem[201] = 32'd2;
        sync_ref();
        run_op(16'd101, 16'd201, 16'd301, 1, 1'b0);
        check("t3_trunc_b", mem[301], 32'hFFFF_FFFE);

        // T4 address wrap
        mem[16'hFFFF] = 32'd5;
        mem[16'h0000] = 32'd7;
        mem[500]      = 32'd11;
        mem[501]      = 32'd13;
        sync_ref();
        run_op(16'hFFFF, 16'd500, 16'd600, 2, 1'b0);
        check("t4_wrap0", mem[600], 32'd55);
        check("t4_wrap1", mem[601], 32'd91);

        // T5 restart attempts and input changes while busy
        mem[0] = 32'd1;
        load_t1();
        sync_ref();
        run_op(16'd0, 16'd4, 16'd20, 4, 1'b1);
        model_op(16'd0, 16'd4, 16'd20, 4);
        compare_mem("t5_mem");

        // T6 reset during WR_C of element 2
        load_t1();
        sync_ref();
        @(negedge clk);
        base_a = 16'd0;
        base_b = 16'd4;
        base_c = 16'd20;
        len    = 16'd4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("t6_in_wr_c", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("t6_rst_write", 32'(mem_write), 32'd0);
        check("t6_rst_addr", 32'(mem_addr), 32'd0);
        check("t6_rst_datain", mem_datain, 32'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        ref_mem[20] = 32'd1;
        ref_mem[21] = 32'd4;
        compare_mem("t6_partial");
        sync_ref();
        run_op(16'd0, 16'd4, 16'd20, 4, 1'b0);
        model_op(16'd0, 16'd4, 16'd20, 4);
        compare_mem("t6_rerun");

        // Randomized runs, including in-place and wrapping windows
        for (int t = 0; t < 20; t++) begin
            n = $urandom_range(1, 8);
            a = 16'($urandom);
            b = 16'($urandom);
            c = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
            for (int i = 0; i < n; i++) begin
                mem[a + 16'(i)] = $urandom;
                mem[b + 16'(i)] = $urandom;
            end
            sync_ref();
            run_op(a, b, c, n, 1'b0);
            model_op(a, b, c, n);
            compare_mem("rand_mem");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
